// File: rtl/systolic_deskew_drain_pkg.sv
// Shared constants, width helpers and the FIFO entry layout for the systolic drain path.
// Default configuration values double as the top-level parameter defaults.
package systolic_deskew_drain_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_LANES      = 4;
    localparam int DEF_ROWS       = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam int LANE_SLICE_W   = DEF_WIDTH;
    localparam int VEC_W          = DEF_LANES * LANE_SLICE_W;

    // Queue entry: last-row flag on top of the aligned row vector.
    typedef struct packed {
        logic             last;
        logic [VEC_W-1:0] data;
    } fifo_entry_t;

    // clog2 that never returns 0, so counters always have at least one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    function automatic int row_cnt_w(input int rows);
        return clog2_min1(rows);
    endfunction

    function automatic int fifo_ptr_w(input int depth);
        return clog2_min1(depth);
    endfunction

endpackage

// File: rtl/systolic_deskew_drain_if.sv
// Array-side input lanes and downstream valid/ready vector bus of the drain block.
// slave is the drain block's view; master is the view of whatever drives the lanes and sinks vectors.
interface systolic_deskew_drain_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 4
);
    logic                   in_en;
    logic [LANES-1:0]       in_valid;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   in_stall;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_data;
    logic                   out_last;
    logic                   err_skew;

    modport master (
        output in_en, in_valid, in_data, out_ready,
        input  in_stall, out_valid, out_data, out_last, err_skew
    );

    modport slave (
        input  in_en, in_valid, in_data, out_ready,
        output in_stall, out_valid, out_data, out_last, err_skew
    );
endinterface

// File: rtl/systolic_deskew_drain_sync_fifo.sv
// Registered synchronous FIFO; head is presented combinationally and forced to zero when empty.
module sync_fifo
    import systolic_deskew_drain_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [W-1:0]                din,
    input  logic                        pop,
    output logic [W-1:0]                dout,
    output logic                        full,
    output logic                        empty,
    output logic [fifo_ptr_w(DEPTH):0]  count
);
    localparam int AW = fifo_ptr_w(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/systolic_deskew_drain.sv
// Realigns skewed systolic column lanes into row vectors, tags the last row of each tile
// and queues the vectors for a valid/ready consumer, stalling the array when the queue fills.
module systolic_deskew_drain
    import systolic_deskew_drain_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LANES      = DEF_LANES,
    parameter int ROWS       = DEF_ROWS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    systolic_deskew_drain_if.slave bus
);
    localparam int VW    = LANES * WIDTH;
    localparam int ROW_W = row_cnt_w(ROWS);
    localparam int CNT_W = fifo_ptr_w(FIFO_DEPTH) + 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic             adv;
    logic             in_stall;
    logic [LANES-1:0] dly_valid;
    logic [VW-1:0]    dly_data;
    logic             push;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
    logic             err_skew_q, err_skew_d;
    logic [VW:0]      push_entry, head_entry;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign in_stall = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign adv      = bus.in_en & ~in_stall;

    // Lane k waits LANES-1-k advances so every lane lines up with the last one.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam int DEPTH = LANES - 1 - gi;
        if (DEPTH == 0) begin : g_pass
            assign dly_valid[gi]              = bus.in_valid[gi];
            assign dly_data[gi*WIDTH +: WIDTH] = bus.in_data[gi*WIDTH +: WIDTH];
        end else begin : g_chain
            logic [WIDTH-1:0] data_q [DEPTH];
            logic [WIDTH-1:0] data_d [DEPTH];
            logic [DEPTH-1:0] valid_q, valid_d;

            always_comb begin
                data_d  = data_q;
                valid_d = valid_q;
                if (adv) begin
                    data_d[0]  = bus.in_data[gi*WIDTH +: WIDTH];
                    valid_d[0] = bus.in_valid[gi];
                    for (int s = 1; s < DEPTH; s++) begin
                        data_d[s]  = data_q[s-1];
                        valid_d[s] = valid_q[s-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= '0;
                    for (int s = 0; s < DEPTH; s++) begin
                        data_q[s] <= '0;
                    end
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign dly_valid[gi]              = valid_q[DEPTH-1];
            assign dly_data[gi*WIDTH +: WIDTH] = data_q[DEPTH-1];
        end
    end

    // A partial set of valids at alignment means the lanes lost lockstep.
    always_comb begin
        push       = 1'b0;
        row_cnt_d  = row_cnt_q;
        err_skew_d = err_skew_q;
        if (adv) begin
            if (&dly_valid) begin
                push      = 1'b1;
                row_cnt_d = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + ROW_W'(1);
            end else if (|dly_valid) begin
                err_skew_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt_q  <= '0;
            err_skew_q <= 1'b0;
        end else begin
            row_cnt_q  <= row_cnt_d;
            err_skew_q <= err_skew_d;
        end
    end

    assign push_entry = {row_cnt_q == LAST_ROW, dly_data};

    sync_fifo #(
        .W     (VW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push & ~fifo_full),
        .din   (push_entry),
        .pop   (bus.out_valid & bus.out_ready),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.in_stall  = in_stall;
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_data  = head_entry[VW-1:0];
    assign bus.out_last  = head_entry[VW];
    assign bus.err_skew  = err_skew_q;

endmodule

// File: tb/tb_systolic_deskew_drain.sv
// Directed bench for systolic_deskew_drain: skewed ramps, backpressure, in_en gaps,
// a dropped lane element, mid-tile reset and a two-tile run under random ready.
module tb_systolic_deskew_drain;
    import systolic_deskew_drain_pkg::*;

    localparam int W  = LANE_SLICE_W;
    localparam int L  = DEF_LANES;
    localparam int R  = DEF_ROWS;
    localparam int D  = DEF_FIFO_DEPTH;
    localparam int VW = W * L;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_deskew_drain_if #(.WIDTH(W), .LANES(L)) bus ();

    systolic_deskew_drain #(
        .WIDTH      (W),
        .LANES      (L),
        .ROWS       (R),
        .FIFO_DEPTH (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int step, n_rows, row_base, drop_lane, drop_row, cyc;
    int first_valid_cyc, first_valid_step;
    fifo_entry_t got_q[$];

    task automatic check_val(input string tag, input logic [VW:0] got, input logic [VW:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        check_val(tag, (VW+1)'(got), (VW+1)'(exp));
    endtask

    function automatic logic [VW-1:0] exp_vec(input int g);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < L; k++) v[k*W +: W] = W'(16 * g + k);
        return v;
    endfunction

    // Ideal skew: at advance step s, lane k presents row s-k.
    task automatic drive_lanes();
        for (int k = 0; k < L; k++) begin
            int j;
            bit v;
            j = step - k;
            v = (j >= 0) && (j < n_rows) && !(k == drop_lane && j == drop_row);
            bus.in_valid[k]        = v;
            bus.in_data[k*W +: W]  = v ? W'(16 * (row_base + j) + k) : '0;
        end
    endtask

    task automatic cycle(input logic en, input logic rdy);
        bit adv;
        bus.in_en     = en;
        bus.out_ready = rdy;
        drive_lanes();
        if (bus.out_valid && first_valid_cyc < 0) begin
            first_valid_cyc  = cyc;
            first_valid_step = step;
        end
        if (bus.out_valid && rdy) got_q.push_back({bus.out_last, bus.out_data});
        adv = en && !bus.in_stall && !rst;
        @(posedge clk);
        @(negedge clk);
        if (adv) step++;
        cyc++;
    endtask

    task automatic start_tile(input int nr, input int base, input int dl, input int dr);
        step = 0; n_rows = nr; row_base = base; drop_lane = dl; drop_row = dr;
        cyc = 0; first_valid_cyc = -1; first_valid_step = -1;
        got_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_en = 1'b0; bus.out_ready = 1'b0; bus.in_valid = '0; bus.in_data = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_int({tag, "_stall"}, int'(bus.in_stall), 0);
        check_int({tag, "_valid"}, int'(bus.out_valid), 0);
        check_int({tag, "_last"},  int'(bus.out_last), 0);
        check_int({tag, "_err"},   int'(bus.err_skew), 0);
        check_val({tag, "_data"},  (VW+1)'(bus.out_data), '0);
    endtask

    // Expected stream: consecutive rows (skipping one if dropped), last on every R-th push.
    task automatic check_stream(input string tag, input int n, input int skip_row);
        check_int({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            int j;
            logic [VW:0] exp;
            j = (skip_row >= 0 && i >= skip_row) ? i + 1 : i;
            exp = {(i % R) == (R - 1), exp_vec(row_base + j)};
            $display("  %s vec %0d row %0d data=%h last=%b", tag, i, j, got_q[i].data, got_q[i].last);
            check_val($sformatf("%s_vec%0d", tag, i), got_q[i], exp);
        end
    endtask

    initial begin
        bus.in_en = 1'b0; bus.out_ready = 1'b0; bus.in_valid = '0; bus.in_data = '0;
        start_tile(0, 0, -1, -1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset");

        // 1: ideal skew, always ready
        start_tile(8, 0, -1, -1);
        for (int c = 0; c < 40 && got_q.size() < 8; c++) cycle(1'b1, 1'b1);
        check_int("t1_first_valid_cyc", first_valid_cyc, 4);
        check_stream("t1", 8, -1);

        // 2: ready low until the queue fills and stalls the array
        do_reset();
        start_tile(8, 0, -1, -1);
        for (int c = 0; c < 20; c++) cycle(1'b1, 1'b0);
        check_int("t2_stall", int'(bus.in_stall), 1);
        check_int("t2_adv_steps", step, 7);
        check_int("t2_popped", got_q.size(), 0);
        check_val("t2_head", {bus.out_last, bus.out_data}, {1'b0, exp_vec(0)});
        for (int c = 0; c < 60 && got_q.size() < 8; c++) cycle(1'b1, 1'b1);
        check_stream("t2", 8, -1);

        // 3: advance only every third cycle
        do_reset();
        start_tile(8, 0, -1, -1);
        for (int c = 0; c < 100 && got_q.size() < 8; c++) cycle(cyc % 3 == 0, 1'b1);
        check_int("t3_first_valid_step", first_valid_step, 4);
        check_int("t3_first_valid_cyc", first_valid_cyc, 10);
        check_stream("t3", 8, -1);

        // 4: lane 2 loses row 3
        do_reset();
        start_tile(8, 0, 2, 3);
        for (int c = 0; c < 20 && step < 6; c++) cycle(1'b1, 1'b1);
        check_int("t4_err_before", int'(bus.err_skew), 0);
        cycle(1'b1, 1'b1);
        check_int("t4_err_after", int'(bus.err_skew), 1);
        for (int c = 0; c < 30; c++) cycle(1'b1, 1'b1);
        check_stream("t4", 7, 3);
        check_int("t4_err_sticky", int'(bus.err_skew), 1);
        do_reset();
        check_int("t4_err_cleared", int'(bus.err_skew), 0);

        // 5: reset with rows 4 and 5 queued and rows 6,7 in flight
        start_tile(8, 0, -1, -1);
        for (int c = 0; c < 30 && step < 9; c++) cycle(1'b1, step < 8);
        check_int("t5_popped_pre", got_q.size(), 4);
        check_val("t5_head_pre", {bus.out_last, bus.out_data}, {1'b0, exp_vec(4)});
        rst = 1'b1;
        cycle(1'b1, 1'b0);
        rst = 1'b0;
        check_idle("t5_post_rst");
        start_tile(8, 20, -1, -1);
        for (int c = 0; c < 40 && got_q.size() < 8; c++) cycle(1'b1, 1'b1);
        check_stream("t5", 8, -1);

        // 6: two tiles back-to-back under random ready
        do_reset();
        start_tile(16, 0, -1, -1);
        for (int c = 0; c < 400 && got_q.size() < 16; c++) cycle(1'b1, $urandom_range(0, 3) != 0);
        for (int c = 0; c < 8; c++) cycle(1'b1, 1'b1);
        check_stream("t6", 16, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
